// File: rtl/approx_seq_divider.sv
// Iterative restoring divider, 2W/W -> W quotient + W remainder, one quotient bit per clock.
// Define APPROX_DIV_EN to build the low APPROX_COLS subtractor columns from the approximate cell.
module approx_seq_divider #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] n,
    input  logic [W-1:0]   d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           ovf,
    output logic           dbz
);

`ifdef APPROX_DIV_EN
    localparam bit APPROX_ON = 1'b1;
`else
    localparam bit APPROX_ON = 1'b0;
`endif
    localparam int ACOLS = !APPROX_ON ? 0 : ((APPROX_COLS > W) ? W : APPROX_COLS);
    localparam int IW    = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [W-1:0]  rem;
    logic [W-1:0]  n_lo;
    logic [W-1:0]  div;
    logic [W-1:0]  q_work;
    logic [IW-1:0] idx;

    logic          qbit;
    logic [W-1:0]  rem_next;

    // One restoring step: {quotient bit, next partial remainder} for P = {R, n[i]}.
    function automatic logic [W:0] sub_step(input logic [W:0] p, input logic [W-1:0] y);
        logic [W-1:0] diff;
        logic [W:0]   bor;
        logic         qb;
        diff   = '0;
        bor    = '0;
        for (int j = 0; j < W; j++) begin
            if (j < ACOLS) begin
                diff[j]  = 1'b0;
                bor[j+1] = ~p[j] & ~bor[j];
            end else begin
                diff[j]  = p[j] ^ y[j] ^ bor[j];
                bor[j+1] = (~p[j] & y[j]) | (~(p[j] ^ y[j]) & bor[j]);
            end
        end
        qb = p[W] | ~bor[W];
        return {qb, qb ? diff : p[W-1:0]};
    endfunction

    always_comb begin
        {qbit, rem_next} = sub_step({rem, n_lo[idx]}, div);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            rem       <= '0;
            n_lo      <= '0;
            div       <= '0;
            q_work    <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_lo     <= n[W-1:0];
                        div      <= d;
                        rem      <= n[2*W-1:W];
                        idx      <= IW'(W - 1);
                        q_work   <= '0;
                        in_ready <= 1'b0;
                        dbz      <= (d == '0);
                        ovf      <= (d != '0) && (n[2*W-1:W] >= d);
                        if (d == '0) begin
                            q         <= '1;
                            r         <= n[W-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem    <= rem_next;
                    q_work <= {q_work[W-2:0], qbit};
                    idx    <= idx - 1'b1;
                    // Results are published only on the final iteration edge.
                    if (idx == '0) begin
                        q         <= {q_work[W-2:0], qbit};
                        r         <= rem_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_seq_divider.sv
// Randomized self-checking bench for approx_seq_divider against a plain-arithmetic divider model.
module tb_approx_seq_divider;
    localparam int W  = 8;
    localparam int AC = 2;
`ifdef APPROX_DIV_EN
    localparam int MAC = AC;
`else
    localparam int MAC = 0;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dbz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    approx_seq_divider #(.W(W), .APPROX_COLS(AC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .ovf(ovf), .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift-and-subtract division; the low MAC columns follow the approximate borrow rule.
    task automatic ref_div(input logic [2*W-1:0] nn, input logic [W-1:0] dd,
                           output logic [W-1:0] eq, output logic [W-1:0] er,
                           output logic eo, output logic ez);
        int rem, qv, p, plo, b, hi, ylo;
        bit take;
        ez = (dd == '0);
        eo = !ez && (nn[2*W-1:W] >= dd);
        if (ez) begin
            eq = '1;
            er = nn[W-1:0];
        end else begin
            rem = int'(nn[2*W-1:W]);
            qv  = 0;
            for (int i = W - 1; i >= 0; i--) begin
                p   = rem * 2 + int'(nn[i]);
                plo = p % (1 << W);
                b   = 0;
                for (int j = 0; j < MAC; j++)
                    b = (((plo >> j) & 1) == 0 && b == 0) ? 1 : 0;
                ylo  = int'(dd) >> MAC;
                hi   = (plo >> MAC) - ylo - b;
                take = (p >= (1 << W)) || (hi >= 0);
                qv   = qv * 2 + (take ? 1 : 0);
                rem  = take ? ((hi & ((1 << (W - MAC)) - 1)) << MAC) : plo;
            end
            eq = W'(qv);
            er = W'(rem);
        end
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [2*W-1:0] nn, input logic [W-1:0] dd, input int hold,
                          output int acc_cyc);
        logic [W-1:0] eq, er;
        logic eo, ez;
        int lat;
        ref_div(nn, dd, eq, er, eo, ez);
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        n         = nn;
        d         = dd;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        acc_cyc = cyc;
        lat = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check_val("latency", 32'(lat), ez ? 32'd1 : 32'(W + 1));
        check_val("q", 32'(q), 32'(eq));
        check_val("r", 32'(r), 32'(er));
        check_val("ovf", 32'(ovf), 32'(eo));
        check_val("dbz", 32'(dbz), 32'(ez));
        check_val("in_ready_busy", 32'(in_ready), 32'd0);
        if (hold > 0) begin
            repeat (hold) begin
                in_valid = 1'($urandom);
                n        = 16'($urandom);
                d        = 8'($urandom);
                @(posedge clk);
                #1;
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_q", 32'(q), 32'(eq));
                check_val("hold_r", 32'(r), 32'(er));
                check_val("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_val("release_valid", 32'(out_valid), 32'd0);
        check_val("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int a0, a1;
        logic [2*W-1:0] rn;
        logic [W-1:0] rd;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n = '0; d = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_r", 32'(r), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_dbz", 32'(dbz), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(16'd1000, 8'd7, 0, a0);
`ifndef APPROX_DIV_EN
        check_val("exact_q", 32'(q), 32'd142);
        check_val("exact_r", 32'(r), 32'd6);
`endif
        run_op(16'd12, 8'd3, 0, a0);
`ifdef APPROX_DIV_EN
        check_val("approx_q", 32'(q), 32'hF7);
        check_val("approx_r", 32'(r), 32'd0);
`else
        check_val("exact12_q", 32'(q), 32'd4);
`endif
        run_op(16'h1234, 8'd0, 5, a0);
        check_val("dbz_q", 32'(q), 32'hFF);
        check_val("dbz_r", 32'(r), 32'h34);
        check_val("dbz_flag", 32'(dbz), 32'd1);
        run_op(16'h0800, 8'd8, 0, a0);
        check_val("ovf_flag", 32'(ovf), 32'd1);

        run_op(16'd500, 8'd9, 0, a0);
        run_op(16'd777, 8'd13, 0, a1);
        check_val("throughput", 32'(a1 - a0), 32'(W + 2));

        // Reset three iterations into a divide.
        n = 16'd1000; d = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_q", 32'(q), 32'd0);
        check_val("midrst_r", 32'(r), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (W + 3) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        check_val("midrst_no_valid", 32'(seen), 32'd0);
        out_ready = 1'b0;
        run_op(16'd1000, 8'd7, 0, a0);

        for (int k = 0; k < 40; k++) begin
            rn = 16'($urandom);
            rd = 8'($urandom);
            if ($urandom_range(7) == 0) rd = '0;
            else if (rd == '0) rd = 8'd1;
            if (rd != '0 && $urandom_range(3) != 0) rn[2*W-1:W] = rn[2*W-1:W] % rd;
            run_op(rn, rd, int'($urandom_range(2)), a0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
